// File: rtl/seg_scan_mux.sv
// seg_scan_mux -- time-multiplexed driver for a common-anode 7-segment
// display with decimal points, per-digit blanking and blinking, and a
// 16-step brightness (PWM) control.
//
// Timing hierarchy:
//   subCnt : 0..SUB_DIV-1       (one sixteenth of a digit slot)
//   phase  : 0..15              (position inside the slot, drives PWM)
//   idx    : 0..NUM_DIGITS-1    (digit being scanned)
//   blink  : 0..BLINK_FRAMES-1  frames per blink half-period
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   en                 scan enable; counters hold and display is dark while low
//   seg_in             active-low patterns, digit i in [8i+7:8i], bit 7 unused
//   dp_mask            1 lights the decimal point of digit i
//   blank_mask         1 forces digit i dark
//   blink_mask         1 makes digit i blink
//   brightness         on-time in sixteenths of a slot (0 = dark, 15 = 15/16)
//   seg                active-low segments, bit 7 is the decimal point
//   an                 active-low anodes
//   digit_idx          digit currently being scanned
//   frame_tick         one-cycle pulse in the cycle idx wraps to 0

module seg_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int SUB_DIV      = 6250,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [8*NUM_DIGITS-1:0]       seg_in,
  input  logic [NUM_DIGITS-1:0]         dp_mask,
  input  logic [NUM_DIGITS-1:0]         blank_mask,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  input  logic [3:0]                    brightness,
  output logic [7:0]                    seg,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_tick
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int SUB_W   = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SUB_W-1:0]   SUB_LAST   = SUB_W'(SUB_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  logic [SUB_W-1:0]      subCnt;
  logic [3:0]            phase;
  logic [IDX_W-1:0]      idx;
  logic [BLINK_W-1:0]    blinkCnt;
  logic                  blinkPhase;
  logic [3:0]            brightQ;

  logic                  lastSub;
  logic                  slotEnd;
  logic                  frameEnd;
  logic                  lit;
  logic [NUM_DIGITS-1:0] anNext;
  logic [7:0]            segNext;

  assign lastSub  = (subCnt == SUB_LAST);
  assign slotEnd  = lastSub && (phase == 4'hF);
  assign frameEnd = slotEnd && (idx == IDX_LAST);

  // The pulse marks the cycle whose clock edge wraps idx back to 0; it can
  // only occur while scanning, and is suppressed during reset.
  assign frame_tick = !rst && en && frameEnd;
  assign digit_idx  = idx;

  // Phase 15 never satisfies phase < brightQ, so every slot ends with at
  // least one dark cycle and adjacent anodes never overlap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    anNext  = '1;
    segNext = 8'hFF;
    lit     = en && (phase < brightQ) && !blank_mask[idx]
              && !(blinkPhase && blink_mask[idx]);
    if (lit) begin
      anNext[idx] = 1'b0;
      segNext     = {~dp_mask[idx], seg_in[8*idx +: 7]};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      subCnt     <= '0;
      phase      <= '0;
      idx        <= '0;
      blinkCnt   <= '0;
      blinkPhase <= 1'b0;
      brightQ    <= '0;
      an         <= '1;
      seg        <= 8'hFF;
    end else begin
      // Outputs are registered from the current counter state and live inputs;
      // anNext/segNext are already dark while en is low.
      an  <= anNext;
      seg <= segNext;

      if (en) begin
        subCnt <= lastSub ? '0 : subCnt + 1'b1;

        if (lastSub) begin
          phase <= phase + 1'b1;  // 4-bit counter wraps 15 -> 0 naturally
        end

        if (slotEnd) begin
          idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
          // Latched only at the slot boundary so a change never cuts a slot.
          brightQ <= brightness;
        end

        if (frameEnd) begin
          if (blinkCnt == BLINK_LAST) begin
            blinkCnt   <= '0;
            blinkPhase <= ~blinkPhase;
          end else begin
            blinkCnt <= blinkCnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux (NUM_DIGITS=4, SUB_DIV=2, BLINK_FRAMES=2).
// The reference model tracks only the number of enabled cycles since reset
// and derives phase, digit, frame and blink state arithmetically from it.

module tb_seg_scan_mux;

  localparam int N     = 4;
  localparam int SD    = 2;
  localparam int BF    = 2;
  localparam int SLOT  = 16 * SD;
  localparam int FRAME = SLOT * N;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] seg_in;
  logic [3:0]  dp_mask;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic [3:0]  brightness;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  seg_scan_mux #(
    .NUM_DIGITS  (N),
    .SUB_DIV     (SD),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .seg_in    (seg_in),
    .dp_mask   (dp_mask),
    .blank_mask(blank_mask),
    .blink_mask(blink_mask),
    .brightness(brightness),
    .seg       (seg),
    .an        (an),
    .digit_idx (digit_idx),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int         vectors     = 0;
  int         miscompares = 0;

  // Reference model state
  int         t         = 0;      // enabled cycles since reset release
  logic [3:0] curBright = 4'h0;   // brightness in force for the current slot
  logic [3:0] expAn     = 4'hF;
  logic [7:0] expSeg    = 8'hFF;
  bit         valid     = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", tag, got, exp, t, $time);
    end
  endtask

  // One clock cycle: check outputs at the falling edge, predict the next
  // registered outputs from the current inputs, then advance the model.
  task automatic step();
    int          phaseM;
    int          idxM;
    int          frameM;
    bit          blinkM;
    bit          tickM;
    bit          litM;
    logic [31:0] byteM;
    @(negedge clk);
    phaseM = (t / SD) % 16;
    idxM   = (t / SLOT) % N;
    frameM = t / FRAME;
    blinkM = ((frameM / BF) % 2) == 1;
    tickM  = !rst && en && ((t % FRAME) == FRAME - 1);

    if (valid) begin
      check("digit_idx",  32'(digit_idx), 32'(idxM));
      check("frame_tick", 32'(frame_tick), 32'(tickM));
      check("an",         32'(an), 32'(expAn));
      check("seg",        32'(seg), 32'(expSeg));
      check("an_overlap", 32'($countones(~an) <= 1), 32'd1);
    end

    litM   = en && (phaseM < int'(curBright)) && !blank_mask[idxM]
             && !(blinkM && blink_mask[idxM]);
    expAn  = 4'hF;
    expSeg = 8'hFF;
    if (litM) begin
      expAn  = 4'hF ^ (4'b0001 << idxM);
      byteM  = seg_in >> (8 * idxM);
      expSeg = {~dp_mask[idxM], byteM[6:0]};
    end

    if (rst) begin
      t         = 0;
      curBright = 4'h0;
      expAn     = 4'hF;
      expSeg    = 8'hFF;
      valid     = 1'b1;
    end else if (en) begin
      if ((t % SLOT) == SLOT - 1) curBright = brightness;
      t++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b1;
    seg_in     = 32'h065B4F66;
    dp_mask    = 4'b0000;
    blank_mask = 4'b0000;
    blink_mask = 4'b0000;
    brightness = 4'd15;
    run(3);
    rst = 1'b0;

    // Scan order at full brightness; first slot stays dark after reset.
    run(2 * FRAME + 4);

    // Duty cycle, fully dark, and a mid-slot brightness change.
    brightness = 4'd4;
    run(FRAME);
    brightness = 4'd0;
    run(FRAME);
    brightness = 4'd4;
    run(SLOT + 5);
    brightness = 4'd12;
    run(SLOT);

    // Decimal point on digit 2, digit 0 blanked.
    brightness = 4'd15;
    dp_mask    = 4'b0100;
    blank_mask = 4'b0001;
    run(FRAME);

    // Blink digit 3 over six frames from a fresh reset.
    dp_mask    = 4'b0000;
    blank_mask = 4'b0000;
    rst        = 1'b1;
    run(2);
    rst        = 1'b0;
    blink_mask = 4'b1000;
    run(6 * FRAME);

    // Enable dropped mid-slot, then reset asserted mid-slot.
    blink_mask = 4'b0000;
    run(SLOT + SLOT / 2 + 3);
    en = 1'b0;
    run(10);
    en = 1'b1;
    run(7);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(2 * SLOT + 10);

    // Randomized traffic: live data/mask changes, enable gaps, rare resets.
    repeat (4000) begin
      if ($urandom_range(15) == 0) seg_in = $urandom;
      if ($urandom_range(63) == 0) dp_mask = 4'($urandom);
      if ($urandom_range(63) == 0) blank_mask = 4'($urandom);
      if ($urandom_range(63) == 0) blink_mask = 4'($urandom);
      if ($urandom_range(39) == 0) brightness = 4'($urandom);
      en  = ($urandom_range(31) != 0);
      rst = ($urandom_range(499) == 0);
      step();
    end
    rst = 1'b0;
    en  = 1'b1;
    run(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, range 2..8.
REQ-002 Parameter SUB_DIV, default 6250: clock cycles per sixteenth of a digit slot; slot length = 16*SUB_DIV cycles; minimum 1.
REQ-003 Parameter BLINK_FRAMES, default 64: full scan frames per blink half-period; minimum 1.
REQ-004 Port clk, input, 1: single clock; all state SHALL be updated on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port en, input, 1: scan enable.
REQ-007 Port seg_in, input, 8*NUM_DIGITS: active-low segment patterns; digit i occupies bits [8i+7:8i], where digit 0 is the rightmost; bit 7 of each byte is ignored.
REQ-008 Port dp_mask, input, NUM_DIGITS: 1 lights the decimal point of digit i.
REQ-009 Port blank_mask, input, NUM_DIGITS: 1 forces digit i dark.
REQ-010 Port blink_mask, input, NUM_DIGITS: 1 makes digit i blink.
REQ-011 Port brightness, input, 4: on-time in sixteenths of a slot; 0 is dark and 15 is 15/16.
REQ-012 Port seg, output, 8: active-low segments, with bit 7 as the decimal point.
REQ-013 Port an, output, NUM_DIGITS: active-low anodes.
REQ-014 Port digit_idx, output, clog2(NUM_DIGITS): index of the digit currently being scanned.
REQ-015 Port frame_tick, output, 1: one-cycle pulse marking the end of a frame.

Function
REQ-016 Prescaler: sub_cnt SHALL count 0..SUB_DIV-1; on wrap, phase SHALL advance 0..15; on phase wrap, digit_idx SHALL advance 0..NUM_DIGITS-1 and then wrap to 0.
REQ-017 When idx wraps from NUM_DIGITS-1 to 0, frame_tick SHALL be 1 for exactly that one cycle.
REQ-018 The blink counter SHALL count frame_ticks 0..BLINK_FRAMES-1; on wrap it SHALL toggle blink_phase.
REQ-019 Brightness SHALL be latched into bright_q in the cycle that idx advances, so a change never takes effect mid-slot.
REQ-020 The digit SHALL be visible when all of the following hold: en=1, phase<bright_q, blank_mask[idx]=0, and not (blink_phase=1 and blink_mask[idx]=1).
REQ-021 Visible digit: an SHALL have only bit idx at 0; seg[6:0] SHALL equal seg_in[8*idx+6 -: 7]; seg[7] SHALL equal ~dp_mask[idx].
REQ-022 Non-visible digit: an SHALL be all 1 and seg SHALL be 8'hFF.
REQ-023 seg and an SHALL be registered with 1-cycle latency relative to the counter state and inputs.
REQ-024 seg_in and the masks SHALL be sampled live each cycle, not latched per slot.
REQ-025 While en=0: all counters SHALL hold; an SHALL be all 1; seg SHALL be 8'hFF; frame_tick SHALL be 0.
REQ-026 When en returns to 1, scanning SHALL resume from the held counter state.
REQ-027 No anode overlap: at most one an bit SHALL be 0 in any cycle.
REQ-028 At every digit change, an SHALL be all 1 for at least one cycle. This holds because phase 15 is never lit (brightness max 15).

Reset
REQ-029 While rst=1: sub_cnt, phase, idx, the blink counter, blink_phase, and bright_q SHALL be 0; an SHALL be all 1; seg SHALL be 8'hFF; frame_tick SHALL be 0.
REQ-030 rst SHALL take priority over en and be effective mid-slot. On the first cycle after release, the module SHALL start at idx 0, phase 0.
REQ-031 Because bright_q=0 after reset, the display SHALL remain dark for the remainder of the first slot.

Verification (NUM_DIGITS=4, SUB_DIV=2, BLINK_FRAMES=2; slot = 32 cycles, frame = 128 cycles)
REQ-032 Scan order: brightness=15, seg_in=32'h06_5B_4F_66, masks 0.
- Required: an steps through 1110, 1101, 1011, 0111 at 32-cycle intervals.
- Required: each digit is lit for 30 cycles with seg equal to its byte's low 7 bits and bit 7 = 1.
- Required: frame_tick pulses every 128 cycles.
REQ-033 Duty cycle: brightness=4.
- Required: an is active for exactly 8 cycles per slot.
- Required: brightness=0 keeps an at 4'hF permanently.
- Required: changing brightness mid-slot takes effect only in the next slot.
REQ-034 Masks: dp_mask=4'b0100, blank_mask=4'b0001.
- Required: seg[7]=0 only while an=1011.
- Required: digit 0's slot shows an=4'hF and seg=8'hFF.
REQ-035 Blink: blink_mask=4'b1000.
- Required: digit 3 is lit during frames 0-1, dark during frames 2-3, lit during frames 4-5.
- Required: the other digits are unaffected.
REQ-036 Enable and reset: drop en mid-slot for 10 cycles, then assert rst mid-slot.
- Required during en=0: outputs go dark 1 cycle later and idx and phase are frozen.
- Required after rst: idx=0, an=4'hF, seg=8'hFF, no frame_tick, and digit 0 is not lit until slot 1 completes.
